led_mode_ctrl: RTL and testbench

Top-level sequencer for the PYNQ Z1 LED pattern design. It debounces the two push buttons, generates the pattern-step `tick`, and enables exactly one LED pattern FSM at a time. It resets the newly selected pattern on every mode change and muxes the selected pattern onto the board LEDs. Each pattern FSM (right-shift, left-shift, blink, …) takes `enable`/`tick`/`reset` from this block and returns a 4-bit `led`.

---
 rtl/led_mode_ctrl_pkg.sv | 17 +
 rtl/led_mode_ctrl_btn_debounce.sv | 58 +++++
 rtl/led_mode_ctrl.sv | 126 ++++++++++++
 tb/tb_led_mode_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_mode_ctrl_pkg.sv
// Shared types and constants for the LED mode sequencer.
package led_mode_ctrl_pkg;

    localparam int LED_W = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSE  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    function automatic logic [3:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/led_mode_ctrl_btn_debounce.sv
// Button synchronizer, debouncer and press-edge detector.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_250_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_d, level_q;
    logic          armed_d, armed_q;
    logic          press_d, press_q;
    logic [CW-1:0] cnt_d, cnt_q;

    // Synchronizer is left unreset so a button held through reset is seen as held.
    always_ff @(posedge clk) begin
        sync1_q <= btn_raw;
        sync2_q <= sync1_q;
    end

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        armed_d = armed_q | ~sync2_q;
        press_d = level_d & ~level_q & armed_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// Mode sequencer: debounced buttons, tick generation, pattern enable and LED mux.
module led_mode_ctrl
    import led_mode_ctrl_pkg::*;
#(
    parameter int N_MODES    = 3,
    parameter int TICK_DIV   = 62_500_000,
    parameter int DEB_CYCLES = 1_250_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     btn_next,
    input  logic                     btn_pause,
    input  logic [LED_W*N_MODES-1:0] mode_led_in,
    output logic [N_MODES-1:0]       mode_en,
    output logic [N_MODES-1:0]       mode_rst,
    output logic                     tick,
    output logic [LED_W-1:0]         led,
    output logic [IDX_W-1:0]         mode_idx,
    output logic                     paused
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0]    TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_MODES - 1);

    logic next_level, next_raw_press, next_press;
    logic pause_level, pause_raw_press, pause_press;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_next),
        .level   (next_level),
        .press   (next_raw_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_pause),
        .level   (pause_level),
        .press   (pause_raw_press)
    );

    assign next_press  = next_raw_press & next_level;
    assign pause_press = pause_raw_press & pause_level;

    state_t             state_d, state_q;
    logic               was_paused_d, was_paused_q;
    logic [IDX_W-1:0]   mode_idx_d, mode_idx_q;
    logic [TW-1:0]      cnt_d, cnt_q;
    logic [N_MODES-1:0] mode_rst_d, mode_rst_q;
    logic [LED_W-1:0]   led_d, led_q, led_sel;
    logic [3:0]         oh_cur, oh_new;

    assign tick = (state_q == ST_RUN) && (cnt_q == TICK_MAX);

    always_comb begin
        state_d      = state_q;
        was_paused_d = was_paused_q;
        mode_idx_d   = mode_idx_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_SWITCH: begin
                state_d = was_paused_q ? ST_PAUSE : ST_RUN;
            end
            ST_RUN, ST_PAUSE: begin
                if (next_press) begin
                    state_d      = ST_SWITCH;
                    was_paused_d = (state_q == ST_PAUSE);
                    mode_idx_d   = (mode_idx_q == IDX_LAST) ? '0 : mode_idx_q + 1'b1;
                    cnt_d        = '0;
                end else if (pause_press) begin
                    state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
                    // A tick issued in the pausing cycle still wraps the count.
                    if (tick) begin
                        cnt_d = '0;
                    end
                end else if (state_q == ST_RUN) begin
                    cnt_d = tick ? '0 : cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        oh_cur     = idx_onehot(mode_idx_q);
        oh_new     = idx_onehot(mode_idx_d);
        mode_rst_d = (state_d == ST_SWITCH) ? oh_new[N_MODES-1:0] : '0;
        led_sel    = '0;
        for (int k = 0; k < N_MODES; k++) begin
            if (mode_idx_q == IDX_W'(k)) begin
                led_sel = mode_led_in[LED_W*k +: LED_W];
            end
        end
        led_d = (state_d == ST_SWITCH) ? '0 : led_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            was_paused_q <= 1'b0;
            mode_idx_q   <= '0;
            cnt_q        <= '0;
            mode_rst_q   <= '0;
            led_q        <= '0;
        end else begin
            state_q      <= state_d;
            was_paused_q <= was_paused_d;
            mode_idx_q   <= mode_idx_d;
            cnt_q        <= cnt_d;
            mode_rst_q   <= mode_rst_d;
            led_q        <= led_d;
        end
    end

    assign mode_en  = (state_q == ST_RUN && !reset) ? oh_cur[N_MODES-1:0] : '0;
    assign mode_rst = mode_rst_q;
    assign led      = led_q;
    assign mode_idx = mode_idx_q;
    assign paused   = (state_q == ST_PAUSE);

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl against a behavioural mode/debounce model.
module tb_led_mode_ctrl;

    localparam int N   = 3;
    localparam int TD  = 4;
    localparam int DEB = 3;

    localparam int M_RUN   = 0;
    localparam int M_PAUSE = 1;
    localparam int M_SW    = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           btn_next = 1'b0;
    logic           btn_pause = 1'b0;
    logic [4*N-1:0] mode_led_in = {4'd3, 4'd2, 4'd1};
    logic [N-1:0]   mode_en, mode_rst;
    logic           tick;
    logic [3:0]     led;
    logic [1:0]     mode_idx;
    logic           paused;

    always #5 clk = ~clk;

    led_mode_ctrl #(
        .N_MODES    (N),
        .TICK_DIV   (TD),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_next    (btn_next),
        .btn_pause   (btn_pause),
        .mode_led_in (mode_led_in),
        .mode_en     (mode_en),
        .mode_rst    (mode_rst),
        .tick        (tick),
        .led         (led),
        .mode_idx    (mode_idx),
        .paused      (paused)
    );

    typedef struct {
        int en;
        int rst;
        int tk;
        int ld;
        int idx;
        int pz;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int st = M_RUN;
    int wasp = 0;
    int mode = 0;
    int phase = 0;
    int exp_led = 0;
    int hist[2][$];
    int lvl[2] = '{0, 0};
    int armed[2] = '{0, 0};
    int last_evt[2] = '{0, 0};
    int pr[2] = '{0, 0};
    int switches = 0;

    function automatic int delayed(input int b, input int s);
        if (s - 2 < 0) return 0;
        return hist[b][s-2];
    endfunction

    task automatic model_edge(input int r, input int rn, input int rp);
        int e, pn, pp, tick_now, shown, all_diff;
        hist[0].push_back(rn);
        hist[1].push_back(rp);
        e = hist[0].size() - 1;
        pn = pr[0];
        pp = pr[1];
        shown = mode;
        tick_now = (st == M_RUN && phase == TD - 1);
        if (r != 0) begin
            st = M_RUN; wasp = 0; mode = 0; phase = 0;
        end else if (st == M_SW) begin
            st = wasp ? M_PAUSE : M_RUN;
        end else if (pn != 0) begin
            wasp = (st == M_PAUSE);
            st = M_SW;
            mode = (mode + 1) % N;
            phase = 0;
            switches++;
        end else if (pp != 0) begin
            if (st == M_RUN) begin
                st = M_PAUSE;
                if (tick_now) phase = 0;
            end else begin
                st = M_RUN;
            end
        end else if (st == M_RUN) begin
            phase = tick_now ? 0 : phase + 1;
        end
        exp_led = (r != 0 || st == M_SW) ? 0 : shown + 1;
        for (int b = 0; b < 2; b++) begin
            if (r != 0) begin
                lvl[b] = 0; armed[b] = 0; pr[b] = 0; last_evt[b] = e;
            end else begin
                all_diff = (e - DEB >= last_evt[b]);
                for (int s = e - DEB + 1; s <= e; s++) begin
                    if (delayed(b, s) == lvl[b]) all_diff = 0;
                end
                pr[b] = 0;
                if (all_diff != 0) begin
                    lvl[b] = 1 - lvl[b];
                    last_evt[b] = e;
                    pr[b] = (lvl[b] == 1 && armed[b] == 1);
                end
                if (delayed(b, e) == 0) armed[b] = 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic n, input logic p);
        exp_t x;
        @(posedge clk);
        model_edge(int'(reset), int'(btn_next), int'(btn_pause));
        #1;
        reset = r;
        btn_next = n;
        btn_pause = p;
        x.en  = (!r && st == M_RUN) ? (1 << mode) : 0;
        x.rst = (st == M_SW) ? (1 << mode) : 0;
        x.tk  = (st == M_RUN && phase == TD - 1);
        x.ld  = exp_led;
        x.idx = mode;
        x.pz  = (st == M_PAUSE);
        sb.push_back(x);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("mode_en", int'(mode_en), x.en);
            chk("mode_rst", int'(mode_rst), x.rst);
            chk("tick", int'(tick), x.tk);
            chk("led", int'(led), x.ld);
            chk("mode_idx", int'(mode_idx), x.idx);
            chk("paused", int'(paused), x.pz);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int sw0, nlev, plev, hold;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        idle(14);

        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        idle(8);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
            idle(6);
        end

        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
        idle(20);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
        idle(12);

        sw0 = switches;
        for (int i = 0; i < 20; i++) step(1'b0, logic'(i % 4 < 2), 1'b0);
        idle(6);
        chk("bounce_no_press", switches, sw0);

        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1);
        idle(10);

        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (st == M_SW) break;
        end
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
        chk("held_next_after_reset", int'(mode_idx), 0);
        idle(8);

        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1);
        chk("held_pause_after_reset", int'(paused), 0);
        idle(8);

        nlev = 0; plev = 0; hold = 0;
        for (int i = 0; i < 900; i++) begin
            if (hold == 0) begin
                nlev = ($urandom_range(0, 2) == 0) ? 1 - nlev : nlev;
                plev = ($urandom_range(0, 3) == 0) ? 1 - plev : plev;
                hold = $urandom_range(1, 9);
            end
            hold--;
            step(logic'($urandom_range(0, 199) == 0), logic'(nlev), logic'(plev));
        end
        idle(4);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
